// File: rtl/cnn_window_gen_if.sv
// Stream interface for cnn_window_gen: pixel input handshake and window
// output handshake bundled together. The "slave" modport is the window
// generator's view; "master" is the environment (pixel source / window sink).
interface cnn_window_gen_if #(
    parameter int PW = 8,
    parameter int K  = 5,
    parameter int CW = 5
);
    logic                PIX_VALID;
    logic [PW-1:0]       PIX_DATA;
    logic                PIX_READY;
    logic                WIN_VALID;
    logic                WIN_READY;
    logic [K*K*PW-1:0]   WIN;
    logic [CW-1:0]       X;
    logic [CW-1:0]       Y;

    modport slave (
        input  PIX_VALID, PIX_DATA, WIN_READY,
        output PIX_READY, WIN_VALID, WIN, X, Y
    );

    modport master (
        output PIX_VALID, PIX_DATA, WIN_READY,
        input  PIX_READY, WIN_VALID, WIN, X, Y
    );
endinterface

// File: rtl/cnn_window_gen.sv
// KxK sliding-window generator for the 5x5 convolution stage.
// Takes a raster-order pixel stream, keeps the previous K-1 rows in a line
// buffer and emits every no-padding window with its top-left coordinate.
// Optional: define CNN_WINDOW_GEN_ERR_EN to build the sticky protocol-error
// flag on ERR; otherwise ERR is tied low.
module cnn_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 5,
    parameter int PW    = 8,
    parameter int CW    = 5
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    START,
    cnn_window_gen_if.slave         bus,
    output logic                    BUSY,
    output logic                    FRAME_DONE,
    output logic                    ERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [CW-1:0]   x_q, x_d;
    logic [CW-1:0]   y_q, y_d;
    logic            win_valid_q, win_valid_d;
    logic            frame_done_q, frame_done_d;
    logic [PW-1:0]   win_q [K][K];
    logic [PW-1:0]   win_d [K][K];
    logic [PW-1:0]   lb_q  [K-1][IMG_W];
    logic [PW-1:0]   lb_d  [K-1][IMG_W];
    logic [PW-1:0]   col_vec [K];

    logic            pix_ready;
    logic            pix_acc;
    logic            win_acc;
    logic            win_hit;
    logic            last_pix;

    assign pix_ready = (state_q == S_STREAM) && (!win_valid_q || bus.WIN_READY);
    assign pix_acc   = pix_ready && bus.PIX_VALID;
    assign win_acc   = win_valid_q && bus.WIN_READY;
    assign win_hit   = (row_q >= CW'(K - 1)) && (col_q >= CW'(K - 1));
    assign last_pix  = (row_q == CW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    assign bus.PIX_READY = pix_ready;
    assign bus.WIN_VALID = win_valid_q;
    assign bus.X         = x_q;
    assign bus.Y         = y_q;
    assign BUSY          = (state_q != S_IDLE);
    assign FRAME_DONE    = frame_done_q;

    // Window element (k,l) lands at bits [(k*K+l)*PW +: PW]
    for (genvar gk = 0; gk < K; gk++) begin : g_win_row
        for (genvar gl = 0; gl < K; gl++) begin : g_win_col
            assign bus.WIN[(gk*K+gl)*PW +: PW] = win_q[gk][gl];
        end
    end

    // Column vector: buffered rows ROW-K+1..ROW-1 of this column, new pixel last
    always_comb begin
        for (int unsigned k = 0; k < K - 1; k++) begin
            col_vec[k] = lb_q[k][col_q];
        end
        col_vec[K-1] = bus.PIX_DATA;
    end

    // Next-state: FSM, raster counters, window shift register, line buffer
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        x_d          = x_q;
        y_d          = y_q;
        win_valid_d  = win_valid_q && !win_acc;
        frame_done_d = (state_q == S_DONE);
        win_d        = win_q;
        lb_d         = lb_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pix_acc) begin
                    // Oldest column drops out on the left, new column enters at l=K-1
                    for (int unsigned k = 0; k < K; k++) begin
                        for (int unsigned l = 0; l < K - 1; l++) begin
                            win_d[k][l] = win_q[k][l+1];
                        end
                        win_d[k][K-1] = col_vec[k];
                    end
                    // Each line-buffer column shifts up one row per accepted pixel
                    for (int unsigned k = 0; k < K - 2; k++) begin
                        lb_d[k][col_q] = lb_q[k+1][col_q];
                    end
                    lb_d[K-2][col_q] = bus.PIX_DATA;

                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + CW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end

                    if (win_hit) begin
                        win_valid_d = 1'b1;
                        x_d         = row_q - CW'(K - 1);
                        y_d         = col_q - CW'(K - 1);
                    end
                    if (last_pix) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (win_acc) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            x_q          <= x_d;
            y_q          <= y_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line buffer storage; contents are don't-care after reset
    always_ff @(posedge CLK) begin
        lb_q <= lb_d;
    end

`ifdef CNN_WINDOW_GEN_ERR_EN
    logic err_q, err_d;

    // Sticky protocol error: pixel offered outside STREAM or START while busy
    always_comb begin
        err_d = err_q;
        if (START && (state_q == S_IDLE)) begin
            err_d = 1'b0;
        end
        if ((bus.PIX_VALID && (state_q != S_STREAM)) || (START && BUSY)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: expected windows are computed from the
// driven image when a pixel is accepted and compared when the DUT shows them.
module tb_cnn_window_gen;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 5;
    localparam int PW    = 8;
    localparam int CW    = 5;
    localparam int NWIN  = (IMG_W - K + 1) * (IMG_H - K + 1);

`ifdef CNN_WINDOW_GEN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [CW-1:0]     x;
        logic [CW-1:0]     y;
        logic [K*K*PW-1:0] win;
        int                cyc;
        bit                seen;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;
    logic START;
    logic BUSY;
    logic FRAME_DONE;
    logic ERR;

    cnn_window_gen_if #(.PW(PW), .K(K), .CW(CW)) bus ();

    cnn_window_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PW(PW), .CW(CW)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .START      (START),
        .bus        (bus),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    logic [PW-1:0] img [IMG_H][IMG_W];
    int          cur_pat = 0;
    int          win_duty = 100;
    int          fd_count = 0;
    int          fd_cyc = 0;
    int          last_acc_cyc = 0;
    int          nwin = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [K*K*PW-1:0] exp_win(input int r0, input int c0);
        logic [K*K*PW-1:0] w;
        w = '0;
        for (int k = 0; k < K; k++)
            for (int l = 0; l < K; l++)
                w[(k*K+l)*PW +: PW] = img[r0+k][c0+l];
        return w;
    endfunction

    task automatic check_idle_outputs();
        chk("rst_pix_ready",  bus.PIX_READY, 0);
        chk("rst_win_valid",  bus.WIN_VALID, 0);
        chk("rst_busy",       BUSY, 0);
        chk("rst_frame_done", FRAME_DONE, 0);
        chk("rst_err",        ERR, 0);
        chk("rst_win",        bus.WIN, 0);
        chk("rst_x",          bus.X, 0);
        chk("rst_y",          bus.Y, 0);
    endtask

    // Window sink: random WIN_READY, compares the shown window to the scoreboard head
    initial begin
        bus.WIN_READY = 1'b0;
        forever begin
            @(negedge CLK);
            bus.WIN_READY = ($urandom_range(99) < win_duty);
            #4;
            if (FRAME_DONE === 1'b1) begin
                fd_count++;
                fd_cyc = cyc;
            end
            if (bus.WIN_VALID === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_win", bus.WIN_VALID, 0);
                end else begin
                    if (!sb[0].seen) begin
                        chk("win_latency", cyc - sb[0].cyc, 1);
                        sb[0].seen = 1'b1;
                    end
                    chk("win_x",   bus.X,   sb[0].x);
                    chk("win_y",   bus.Y,   sb[0].y);
                    chk("win_dat", bus.WIN, sb[0].win);
                    if (bus.WIN_READY) begin
                        if (bus.X == 0 && bus.Y == 0)
                            chk("w00_e44", bus.WIN[24*PW +: PW], (cur_pat == 0) ? 116 : 8);
                        if (cur_pat == 0 && bus.X == 23 && bus.Y == 23)
                            chk("wlast_e44", bus.WIN[24*PW +: PW], 8'h0F);
                        void'(sb.pop_front());
                        nwin++;
                        last_acc_cyc = cyc;
                    end else begin
                        chk("stall_pix_ready", bus.PIX_READY, 0);
                    end
                end
            end
        end
    end

    task automatic run_frame(input int pat, input int wduty, input int pduty,
                             input int abort_at, input int busy_at);
        int  t;
        bit  exp_err;
        exp_err  = (busy_at >= 0) ? ERR_EN : 1'b0;
        cur_pat  = pat;
        win_duty = wduty;
        fd_count = 0;
        nwin     = 0;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = (pat == 0) ? PW'(r*IMG_W + c) : PW'(r + c);

        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        #4;
        chk("busy_after_start", BUSY, 1);
        chk("err_cleared",      ERR, 0);

        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (r*IMG_W + c == abort_at) begin
                    @(negedge CLK); bus.PIX_VALID = 1'b0; nRST = 1'b0;
                    @(negedge CLK); nRST = 1'b1;
                    #4;
                    check_idle_outputs();
                    sb.delete();
                    repeat (40) @(negedge CLK);
                    #4;
                    chk("abort_no_done", fd_count, 0);
                    return;
                end
                if (r*IMG_W + c == busy_at) begin
                    @(negedge CLK); bus.PIX_VALID = 1'b0; START = 1'b1;
                    @(negedge CLK); START = 1'b0;
                    #4;
                    chk("err_start_busy",  ERR, ERR_EN);
                    chk("busy_start_kept", BUSY, 1);
                end
                while ($urandom_range(99) >= pduty) begin
                    @(negedge CLK); bus.PIX_VALID = 1'b0;
                end
                @(negedge CLK);
                bus.PIX_VALID = 1'b1;
                bus.PIX_DATA  = img[r][c];
                #4;
                t = 0;
                while (!bus.PIX_READY && t < 1000) begin
                    @(negedge CLK); #4; t++;
                end
                if (!bus.PIX_READY) begin
                    chk("pix_accept_timeout", bus.PIX_READY, 1);
                    bus.PIX_VALID = 1'b0;
                    return;
                end
                if (r >= K-1 && c >= K-1)
                    sb.push_back('{x: CW'(r-K+1), y: CW'(c-K+1),
                                   win: exp_win(r-K+1, c-K+1), cyc: cyc, seen: 1'b0});
            end
        end
        @(negedge CLK); bus.PIX_VALID = 1'b0;
        #4;
        t = 0;
        while (FRAME_DONE !== 1'b1 && t < 5000) begin
            @(negedge CLK); #4; t++;
        end
        chk("frame_done_seen", FRAME_DONE, 1);
        repeat (4) @(negedge CLK);
        #4;
        chk("frame_done_count", fd_count, 1);
        chk("frame_done_lat",   fd_cyc - last_acc_cyc, 2);
        chk("num_windows",      nwin, NWIN);
        chk("scoreboard_empty", sb.size(), 0);
        chk("busy_end",         BUSY, 0);
        chk("err_end",          ERR, exp_err);
    endtask

    // Main sequence
    initial begin
        nRST          = 1'b0;
        START         = 1'b0;
        bus.PIX_VALID = 1'b0;
        bus.PIX_DATA  = '0;
        repeat (3) @(negedge CLK);
        #4;
        check_idle_outputs();
        @(negedge CLK); nRST = 1'b1;

        // Pixels offered while idle are refused
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus.PIX_VALID = 1'b1;
            bus.PIX_DATA  = PW'(8'hA0 + i);
            #4;
            chk("idle_pix_ready", bus.PIX_READY, 0);
        end
        @(negedge CLK); bus.PIX_VALID = 1'b0;
        #4;
        chk("idle_err",    ERR, ERR_EN);
        chk("idle_no_win", bus.WIN_VALID, 0);

        run_frame(0, 100, 100,  -1,  -1);   // full frame, no stalls
        run_frame(0,  30, 100,  -1,  -1);   // output backpressure
        run_frame(0, 100,  50,  -1,  -1);   // input gaps
        run_frame(0, 100, 100, 300,  -1);   // reset mid-frame
        run_frame(1, 100, 100,  -1,  -1);   // frame after reset
        run_frame(0,  70,  80,  -1, 100);   // START while busy
        run_frame(1, 100, 100,  -1,  -1);   // honoured START clears ERR

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnn_window_gen.md
Name: cnn_window_gen

Overview:
- Upstream feeder for the 5x5 convolution stage of the simple CNN.
- Accepts one frame as a raster-order stream of 28x28 8-bit pixels with a valid/ready handshake, buffers the previous K-1 rows in a line buffer, and emits every valid (no-padding) KxK window.
- Each window is emitted once with its top-left row/column coordinate: 24x24 = 576 windows per frame.
- Output packing matches the convolution stage's IMGIN/X/Y inputs, so the window bus connects to them directly.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
K, 5, window edge length
PW, 8, pixel width in bits
CW, 5, coordinate width for ROW/COL and X/Y (must hold max(IMG_W,IMG_H)-1)

Ports:
CLK  in  1  clock
nRST  in  1  reset, synchronous, active-low
START  in  1  one-cycle pulse; begins a frame, honoured only in IDLE
PIX_VALID  in  1  PIX_DATA valid
PIX_DATA  in  PW  pixel, raster order, row 0 col 0 first
PIX_READY  out  1  pixel accepted on cycles where PIX_VALID && PIX_READY
WIN_VALID  out  1  WIN/X/Y hold a window
WIN_READY  in  1  downstream accepts the window on WIN_VALID && WIN_READY
WIN  out  K*K*PW  window; element (k,l) (k = row offset, l = col offset) at bits [(k*K+l)*PW +: PW]
X  out  CW  window top-left row, 0..IMG_H-K
Y  out  CW  window top-left column, 0..IMG_W-K
BUSY  out  1  high in any state other than IDLE
FRAME_DONE  out  1  one-cycle pulse after the last window is accepted
ERR  out  1  protocol error flag (see Optional Feature)

Behaviour:
- **Reset (nRST low at posedge):**
  - State goes to IDLE.
  - PIX_READY, WIN_VALID, BUSY, FRAME_DONE and ERR are 0; WIN, X and Y are 0.
  - Row and column counters are 0.
  - Line buffer contents are don't-care.
  - Reset mid-frame abandons the frame; no FRAME_DONE is produced.
- **States:** IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
  - IDLE: PIX_READY=0. When START=1: clear ROW/COL, go to STREAM.
  - STREAM: PIX_READY = !WIN_VALID || WIN_READY (combinational). This is the only combinational path from WIN_READY to PIX_READY.
  - On each accepted pixel at (ROW,COL):
    - Column vector = line-buffer column COL rows ROW-K+1..ROW-1, plus the new pixel.
    - The column vector is shifted into the KxK window shift register (oldest column drops out).
    - Line-buffer column COL is updated with the new pixel.
    - COL increments; at IMG_W-1 it wraps to 0 and ROW increments.
  - Window emission: if ROW>=K-1 and COL>=K-1 at acceptance, the next cycle has WIN_VALID=1, WIN = the updated shift register, X=ROW-K+1, Y=COL-K+1. Latency is 1 cycle from pixel accept to WIN_VALID.
  - WIN_VALID/WIN/X/Y stay stable until the window is accepted.
  - WIN_VALID clears after acceptance unless a new window loads on the same cycle; back-to-back windows are allowed at 1 per cycle.
  - Acceptance of pixel (IMG_H-1, IMG_W-1) moves the state to DRAIN.
  - DRAIN: PIX_READY=0. When the final window is accepted, go to DONE.
  - DONE: FRAME_DONE=1 for exactly one cycle, then IDLE.
- **START handling:** START outside IDLE is ignored.
- **Pixel gaps:** idle PIX_VALID cycles (gaps) are legal anywhere in the frame.
- **Border pixels:** pixels with ROW<K-1 or COL<K-1 only fill buffers and produce no window.
- **Simultaneous events:** if a window is accepted in the same cycle that a new window-producing pixel is accepted, the new window loads with no bubble.
- **Arithmetic:** pixels are unsigned and passed through unmodified. There is no arithmetic on data.

Optional Feature:
- Macro: CNN_WINDOW_GEN_ERR_EN.
- **Defined:** ERR becomes a sticky flag. It is set on any cycle where PIX_VALID=1 while the state is not STREAM, or where START=1 while BUSY=1. It clears only on reset or on a START honoured in IDLE (that START clears ERR while starting the frame). ERR updates one cycle after the offending event.
- **Not defined:** ERR is tied to 0 and no detection logic is built.

Test Plan:
1. **Full frame, no stalls.** START, then 784 pixels, value (r*28+c)&0xFF, WIN_READY=1 -> exactly 576 windows in raster order. Window (0,0): element (k,l) = k*28+l, e.g. bits[7:0]=0, element (4,4)=116. Last window: X=23, Y=23, element (4,4) = (27*28+27)&0xFF = 0x0F. FRAME_DONE pulses once, 2 cycles after the final window accept.
2. **Backpressure.** Random WIN_READY with 30% duty -> same 576 windows, identical contents. While WIN_VALID=1 && WIN_READY=0, PIX_READY=0 and WIN/X/Y are stable.
3. **Input gaps.** Random PIX_VALID with 50% duty -> identical window sequence to scenario 1. The first WIN_VALID occurs 1 cycle after pixel (4,4) is accepted.
4. **Reset mid-frame.** nRST low after 300 pixels -> all outputs 0 next cycle and no FRAME_DONE. A following full frame with value (r+c)&0xFF gives window (0,0) element (4,4) = 8.
5. **START while busy.** START pulse at pixel 100 -> ignored; the frame completes with 576 windows. With CNN_WINDOW_GEN_ERR_EN: ERR=1 from the next cycle, and the next honoured START clears it.
6. **Pixels outside a frame.** PIX_VALID=1 in IDLE -> PIX_READY=0 and no window produced. ERR=1 only when CNN_WINDOW_GEN_ERR_EN is defined.
